// File: rtl/sha_mem_responder.sv
// Word memory behind the SHA-256 core: 1-cycle registered core reads, host access while the core is deselected,
// and in-order capture of the eight digest words written into the output window.
module sha_mem_responder #(
   parameter int DEPTH = 1024
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          core_sel,
   input  logic          mem_we,
   input  logic [15:0]   mem_addr,
   input  logic [31:0]   mem_write_data,
   output logic [31:0]   mem_read_data,
   input  logic [15:0]   output_addr,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [15:0]   host_addr,
   input  logic [31:0]   host_wdata,
   output logic [31:0]   host_rdata,
   output logic          host_ack,
   output logic [255:0]  digest,
   output logic          digest_valid,
   output logic          seq_err,
   output logic          oob_err,
   input  logic          digest_clr
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   typedef enum logic {H_IDLE, H_ACK} hstate_t;

   logic [31:0]       mem [DEPTH];
   hstate_t           hstate;
   logic [7:0][31:0]  dig;
   logic [3:0]        wr_cnt;

   logic        core_in;
   logic        host_in;
   logic        core_wr;
   logic        host_go;
   logic [15:0] k_full;
   logic [2:0]  k;
   logic        in_win;

   assign core_in = {1'b0, mem_addr} < DEPTH_W;
   assign host_in = {1'b0, host_addr} < DEPTH_W;
   assign core_wr = core_sel && mem_we;
   assign host_go = (hstate == H_IDLE) && host_req && !core_sel;

   // 16-bit wrap is intended: addresses below the window give a huge k and miss.
   assign k_full = mem_addr - output_addr;
   assign k      = k_full[2:0];
   assign in_win = core_wr && (k_full < 16'd8);

   assign digest = dig;

   always_ff @(posedge clk) begin
      if (core_wr && core_in)
         mem[mem_addr[AW-1:0]] <= mem_write_data;
      else if (host_go && host_we && host_in)
         mem[host_addr[AW-1:0]] <= host_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         mem_read_data <= '0;
      else if (core_sel && !mem_we)
         mem_read_data <= core_in ? mem[mem_addr[AW-1:0]] : 32'h0;
   end

   // Ack is registered one cycle after acceptance; an accepted access finishes regardless of core_sel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hstate     <= H_IDLE;
         host_ack   <= 1'b0;
         host_rdata <= '0;
      end else begin
         case (hstate)
            H_IDLE: begin
               host_ack <= 1'b0;
               if (host_go) begin
                  if (!host_we)
                     host_rdata <= host_in ? mem[host_addr[AW-1:0]] : 32'h0;
                  hstate <= H_ACK;
               end
            end
            H_ACK: begin
               host_ack <= 1'b1;
               hstate   <= H_IDLE;
            end
            default: begin
               host_ack <= 1'b0;
               hstate   <= H_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         oob_err <= 1'b0;
      else if ((core_sel && !core_in) || (host_go && !host_in))
         oob_err <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dig          <= '0;
         wr_cnt       <= '0;
         digest_valid <= 1'b0;
         seq_err      <= 1'b0;
      end else if (digest_clr) begin
         wr_cnt       <= '0;
         digest_valid <= 1'b0;
         seq_err      <= 1'b0;
      end else if (in_win) begin
         if ({1'b0, k} <= wr_cnt) begin
            dig[3'd7 - k] <= mem_write_data;
            if ({1'b0, k} == wr_cnt) begin
               wr_cnt <= wr_cnt + 4'd1;
               if (wr_cnt == 4'd7)
                  digest_valid <= 1'b1;
            end
         end else begin
            seq_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench for sha_mem_responder: host preload/readback, core reads, digest capture, arbitration, out-of-range, reset.
module tb_sha_mem_responder;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          core_sel;
   logic          mem_we;
   logic [15:0]   mem_addr;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;
   logic [15:0]   output_addr;
   logic          host_req;
   logic          host_we;
   logic [15:0]   host_addr;
   logic [31:0]   host_wdata;
   logic [31:0]   host_rdata;
   logic          host_ack;
   logic [255:0]  digest;
   logic          digest_valid;
   logic          seq_err;
   logic          oob_err;
   logic          digest_clr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sha_mem_responder #(.DEPTH(1024)) dut (
      .clk(clk), .reset_n(reset_n), .core_sel(core_sel), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .output_addr(output_addr), .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
      .host_ack(host_ack), .digest(digest), .digest_valid(digest_valid),
      .seq_err(seq_err), .oob_err(oob_err), .digest_clr(digest_clr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns in the ack cycle; lat counts edges from request to visible ack (20 = timed out).
   task automatic host_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
      host_we    = we;
      host_addr  = addr;
      host_wdata = wdata;
      host_req   = 1'b1;
      lat        = 0;
      do begin
         step();
         lat++;
      end while (host_ack !== 1'b1 && lat < 20);
      rdata    = host_rdata;
      host_req = 1'b0;
      host_we  = 1'b0;
   endtask

   task automatic core_write(input logic [15:0] addr, input logic [31:0] data);
      core_sel       = 1'b1;
      mem_we         = 1'b1;
      mem_addr       = addr;
      mem_write_data = data;
      step();
      mem_we = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      core_sel = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
      output_addr = 16'h0100; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
      host_wdata = '0; digest_clr = 1'b0;
      step(); step();
      checks++; if (mem_read_data !== 32'h0) begin failures++; $display("FAIL reset_rd got %h exp 0", mem_read_data); end
      checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b exp 0", host_ack); end
      checks++; if (host_rdata !== 32'h0) begin failures++; $display("FAIL reset_hrd got %h exp 0", host_rdata); end
      checks++; if (digest !== 256'h0) begin failures++; $display("FAIL reset_digest got %h exp 0", digest); end
      checks++; if ({digest_valid, seq_err, oob_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b exp 000", {digest_valid, seq_err, oob_err}); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_host_preload();
      logic [31:0] rd;
      int lat;
      for (int i = 0; i < 20; i++) begin
         host_xfer(1'b1, 16'(i), 32'h01234567 + 32'(i), rd, lat);
         checks++; if (lat !== 2) begin failures++; $display("FAIL host_wr_lat[%0d] got %0d exp 2", i, lat); end
      end
      for (int i = 0; i < 20; i++) begin
         host_xfer(1'b0, 16'(i), 32'h0, rd, lat);
         checks++;
         if (lat !== 2 || rd !== 32'h01234567 + 32'(i)) begin
            failures++;
            $display("FAIL host_rd[%0d] got lat=%0d data=%h exp lat=2 data=%h", i, lat, rd, 32'h01234567 + 32'(i));
         end
      end
      step();
      checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL host_ack_pulse got %b exp 0", host_ack); end
      checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL preload_oob got %b exp 0", oob_err); end
   endtask

   task automatic test_core_read();
      core_sel = 1'b1; mem_we = 1'b0; mem_addr = 16'd5;
      step();
      checks++; if (mem_read_data !== 32'h0123456C) begin failures++; $display("FAIL core_rd1 got %h exp 0123456c", mem_read_data); end
      step();
      checks++; if (mem_read_data !== 32'h0123456C) begin failures++; $display("FAIL core_rd2 got %h exp 0123456c", mem_read_data); end
      core_write(16'd7, 32'hDEADBEEF);
      checks++; if (mem_read_data !== 32'h0123456C) begin failures++; $display("FAIL core_wr_hold got %h exp 0123456c", mem_read_data); end
      mem_addr = 16'd7;
      step();
      checks++; if (mem_read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL core_raw got %h exp deadbeef", mem_read_data); end
   endtask

   task automatic test_digest();
      output_addr = 16'h0100;
      for (int k = 0; k < 8; k++) begin
         core_write(16'h0100 + 16'(k), 32'hA0 + 32'(k));
         if (k == 6) begin
            checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL dig_valid_early got %b exp 0", digest_valid); end
         end
      end
      checks++; if (digest_valid !== 1'b1) begin failures++; $display("FAIL dig_valid got %b exp 1", digest_valid); end
      checks++; if (digest[255:224] !== 32'hA0) begin failures++; $display("FAIL dig_w0 got %h exp a0", digest[255:224]); end
      checks++; if (digest[223:192] !== 32'hA1) begin failures++; $display("FAIL dig_w1 got %h exp a1", digest[223:192]); end
      checks++; if (digest[31:0] !== 32'hA7) begin failures++; $display("FAIL dig_w7 got %h exp a7", digest[31:0]); end
      checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL dig_seq got %b exp 0", seq_err); end
      core_write(16'h0103, 32'hB3);
      checks++; if (digest[159:128] !== 32'hB3) begin failures++; $display("FAIL dig_overwrite got %h exp b3", digest[159:128]); end
      checks++; if ({digest_valid, seq_err} !== 2'b10) begin failures++; $display("FAIL dig_after_ow got %b exp 10", {digest_valid, seq_err}); end
   endtask

   task automatic test_seq_err();
      digest_clr = 1'b1;
      step();
      digest_clr = 1'b0;
      checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got %b exp 0", digest_valid); end
      core_write(16'h0100, 32'h11);
      core_write(16'h0102, 32'h22);
      checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL seq_err got %b exp 1", seq_err); end
      checks++; if (dut.wr_cnt !== 4'd1) begin failures++; $display("FAIL seq_wr_cnt got %0d exp 1", dut.wr_cnt); end
      checks++; if (digest[191:160] !== 32'hA2) begin failures++; $display("FAIL seq_nocap got %h exp a2", digest[191:160]); end
      mem_addr = 16'h0102;
      step();
      checks++; if (mem_read_data !== 32'h22) begin failures++; $display("FAIL seq_memwr got %h exp 22", mem_read_data); end
      digest_clr = 1'b1;
      core_write(16'h0100, 32'h33);
      digest_clr = 1'b0;
      checks++; if ({seq_err, digest_valid} !== 2'b00) begin failures++; $display("FAIL clr_flags got %b exp 00", {seq_err, digest_valid}); end
      checks++; if (dut.wr_cnt !== 4'd0) begin failures++; $display("FAIL clr_prio got %0d exp 0", dut.wr_cnt); end
   endtask

   task automatic test_arbitration();
      int lat;
      core_sel = 1'b1; mem_we = 1'b0; mem_addr = 16'd2;
      host_we = 1'b0; host_addr = 16'd3; host_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL arb_stall[%0d] got %b exp 0", i, host_ack); end
      end
      checks++; if (mem_read_data !== 32'h01234569) begin failures++; $display("FAIL arb_core_rd got %h exp 01234569", mem_read_data); end
      core_sel = 1'b0;
      mem_addr = 16'd4;
      lat = 0;
      do begin
         step();
         lat++;
      end while (host_ack !== 1'b1 && lat < 20);
      host_req = 1'b0;
      checks++; if (lat !== 2) begin failures++; $display("FAIL arb_lat got %0d exp 2", lat); end
      checks++; if (host_rdata !== 32'h0123456A) begin failures++; $display("FAIL arb_data got %h exp 0123456a", host_rdata); end
      checks++; if (mem_read_data !== 32'h01234569) begin failures++; $display("FAIL arb_rd_hold got %h exp 01234569", mem_read_data); end
      step();
      checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL arb_ack_once got %b exp 0", host_ack); end
   endtask

   task automatic test_oob_and_reset();
      logic [31:0] rd;
      int lat;
      host_xfer(1'b1, 16'd1024, 32'h55, rd, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL oob_wr_lat got %0d exp 2", lat); end
      checks++; if (oob_err !== 1'b1) begin failures++; $display("FAIL oob_err got %b exp 1", oob_err); end
      host_xfer(1'b0, 16'd1024, 32'h0, rd, lat);
      checks++; if (lat !== 2 || rd !== 32'h0) begin failures++; $display("FAIL oob_rd got lat=%0d data=%h exp lat=2 data=0", lat, rd); end
      host_xfer(1'b0, 16'd0, 32'h0, rd, lat);
      checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL pre_rst_ack got %b exp 1", host_ack); end
      reset_n = 1'b0;
      #1;
      checks++; if ({host_ack, host_rdata} !== 33'h0) begin failures++; $display("FAIL rst_host got %b/%h exp 0/0", host_ack, host_rdata); end
      checks++; if (mem_read_data !== 32'h0 || digest !== 256'h0) begin failures++; $display("FAIL rst_data got %h/%h exp 0/0", mem_read_data, digest); end
      checks++; if ({digest_valid, seq_err, oob_err} !== 3'b000) begin failures++; $display("FAIL rst_flags got %b exp 000", {digest_valid, seq_err, oob_err}); end
      reset_n = 1'b1;
      host_we = 1'b0; host_addr = 16'd1; host_req = 1'b1;
      step();
      reset_n = 1'b0;
      host_req = 1'b0;
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL abort_ack[%0d] got %b exp 0", i, host_ack); end
      end
   endtask

   initial begin
      test_reset();
      test_host_preload();
      test_core_read();
      test_digest();
      test_seq_err();
      test_arbitration();
      test_oob_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sha_mem_responder.md
# sha_mem_responder

Word-addressed memory responder on the far end of the SHA-256 core's memory bus. It serves the core's reads with one-cycle registered latency, absorbs its writes, and captures the eight digest words as they are written. A host port preloads the message and reads results back while the core is not selected.

## Interface
- DEPTH, 1024: number of 32-bit words. Valid addresses are 0..DEPTH-1.
- clk  in  1  single clock. The core's mem_clk is this clock.
- reset_n  in  1  asynchronous, active-low reset.
- core_sel  in  1  1 = the core owns the array; 0 = the host owns it.
- mem_we  in  1  core write enable.
- mem_addr  in  16  core word address.
- mem_write_data  in  32  core write data.
- mem_read_data  out  32  registered read data to the core.
- output_addr  in  16  base address of the digest window, output_addr..output_addr+7.
- host_req  in  1  host request. Level signal, held until host_ack.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data. Valid only while host_ack is high.
- host_ack  out  1  one-cycle completion pulse.
- digest  out  256  captured digest. Word k occupies bits [255-32k -: 32].
- digest_valid  out  1  all eight digest words captured. Sticky.
- seq_err  out  1  out-of-order digest write seen. Sticky.
- oob_err  out  1  out-of-range access seen. Sticky.
- digest_clr  in  1  synchronous clear of the capture state.

## Operation
- Array: DEPTH x 32, not reset.
- Core port, active when core_sel=1:
  - Serviced every cycle; there is no valid strobe.
  - mem_we=1: mem[mem_addr] <= mem_write_data at the posedge.
  - mem_we=0: mem_read_data <= mem[mem_addr] at the posedge.
  - During a write cycle mem_read_data holds its previous value.
- Host port, active when core_sel=0. Two-state FSM: H_IDLE, H_ACK.
  - H_IDLE with host_req=1 and core_sel=0: perform the access (write, or read into host_rdata) and go to H_ACK.
  - H_ACK: host_ack=1 for exactly one cycle, then return to H_IDLE.
  - The host must drop or change host_req in the ack cycle. host_req still high in H_IDLE starts a new access.
- Arbitration:
  - core_sel=1 stalls the host. host_req waits in H_IDLE with no ack.
  - An access already accepted always completes its ack, even if core_sel rises during H_ACK.
  - While core_sel=0, core inputs are ignored and mem_read_data holds.
- Out of range (addr >= DEPTH), either port:
  - Writes are dropped.
  - Reads return 32'h0.
  - oob_err is set.
  - A host out-of-range access is still acked.
- Digest capture, core writes only. Counter wr_cnt runs 0..8. Let k = mem_addr - output_addr (16-bit), with k < 8.
  - k == wr_cnt: digest word k <= data, wr_cnt++.
  - k < wr_cnt: overwrite digest word k. wr_cnt unchanged, no error.
  - k > wr_cnt: seq_err=1, no capture. The memory write still happens.
  - Writes outside the window do not affect capture.
  - digest_valid=1 once wr_cnt==8. Further window writes behave as the k < wr_cnt case.
- digest_clr clears wr_cnt, digest_valid and seq_err. It takes priority over a capture in the same cycle.
- oob_err is cleared only by reset.

## Timing
- Reset values: mem_read_data=0, host_rdata=0, host_ack=0, digest=0, digest_valid=0, seq_err=0, oob_err=0, wr_cnt=0, FSM=H_IDLE.
- Reset mid-operation aborts any pending host access; no ack is issued.
- Core read latency is 1 cycle: address at edge N, data valid after edge N, usable at edge N+1.
- Core write followed by a read of the same address on the next cycle returns the new data.
- Host latency: request sampled at edge N → host_ack and host_rdata valid in cycle N+1, i.e. after edge N+1.
- digest_valid rises in the cycle after the edge that captures word 7.
- All flags and the digest update on clk posedge only.

## Test plan
- Host preload: write mem[0..19]=32'h01234567+i, read all 20 back → each read acked one cycle after acceptance with the matching data; oob_err=0.
- Core read: core_sel=1, mem_addr=5 held two cycles → mem_read_data=32'h0123456C after the first edge.
- Digest capture: output_addr=16'h0100, core writes words 0..7 in order with 32'hA0+k → digest_valid=1 one cycle after the last write; digest[255:224]=32'hA0, digest[31:0]=32'hA7; seq_err=0.
- Sequence error: output_addr=16'h0100, write 0x100, then 0x102 → seq_err=1, wr_cnt=1, mem[0x102] updated. Then digest_clr → seq_err=0, digest_valid=0.
- Arbitration: host_req read pending with core_sel=1 for 10 cycles → no host_ack. core_sel falls → host_ack two cycles later with correct data.
- Out of range with DEPTH=1024: host write to 1024, then host read of 1024 → both acked, read returns 0, oob_err=1. Reset asserted mid-ack → all outputs at reset values.
